// File: rtl/crc7.sv
// Serial MSB-first CRC7 generator/checker for the SD command line (x^7 + x^3 + 1).
// Accumulates one message bit per clock while iunload=0 and shifts the remainder out while iunload=1.
`timescale 1ns/1ps
module crc7 #(
  parameter int                 CRC_LEN = 7,
  parameter logic [CRC_LEN-1:0] POLY    = 7'b0001001,
  parameter logic [CRC_LEN-1:0] INIT    = 7'b0000000
) (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  logic [CRC_LEN-1:0] r;
  logic               fb;

  assign fb = idata ^ r[CRC_LEN-1];

  // Unload is a plain shift, so seven unload cycles leave r at zero for the next message.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r <= INIT;
    end else if (iunload) begin
      r <= {r[CRC_LEN-2:0], 1'b0};
    end else begin
      r <= {r[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY : {CRC_LEN{1'b0}});
    end
  end

  // Combinational so the first CRC bit appears as soon as iunload rises.
  assign ocrc = irst & iunload & r[CRC_LEN-1];

endmodule

// File: tb/tb_crc7.sv
// Bench for crc7: directed SD command/response vectors, expected CRC bits queued by the
// drivers and popped by a monitor on every falling edge during unload.
`timescale 1ns/1ps
module tb_crc7;

  logic iclk;
  logic irst;
  logic idata;
  logic iunload;
  logic ocrc;

  int n_tests = 0;
  int n_fail  = 0;
  int bit_idx = 0;

  logic [0:0] exp_q[$];

  localparam logic [39:0] CMD0   = 40'h40_0000_0000;
  localparam logic [39:0] CMD17  = 40'h51_0000_0000;
  localparam logic [39:0] RESP17 = 40'h11_0000_0900;

  crc7 dut (
    .iclk    (iclk),
    .irst    (irst),
    .idata   (idata),
    .iunload (iunload),
    .ocrc    (ocrc)
  );

  // Clock / reset
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Drivers: inputs change 1 ns after the rising edge.
  task automatic do_reset();
    irst    = 1'b0;
    idata   = 1'b0;
    iunload = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    irst = 1'b1;
  endtask

  task automatic send_bits(input logic [63:0] m, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      idata   = m[i];
      iunload = 1'b0;
      @(posedge iclk);
      #1;
    end
    idata = 1'b0;
  endtask

  task automatic unload(input logic [6:0] exp_crc, input int n);
    logic [6:0] e;
    e = exp_crc;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back((k < 7) ? e[6-k] : 1'b0);
      iunload = 1'b1;
      idata   = k[0];
      @(posedge iclk);
      #1;
    end
    iunload = 1'b0;
    idata   = 1'b0;
  endtask

  task automatic check_now(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [0:0] e;
    forever begin
      @(negedge iclk);
      if (iunload === 1'b1 && irst === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unload_underflow: ocrc=%b with no expected bit queued", ocrc);
        end else begin
          e = exp_q.pop_front();
          if (ocrc !== e[0]) begin
            n_fail++;
            $display("[TB] FAIL crc_bit %0d: got %b, expected %b", bit_idx, ocrc, e[0]);
          end
        end
        bit_idx++;
      end
    end
  end

  // Stimulus
  initial begin
    do_reset();

    // Reset state: remainder is zero, so the first unloaded bit is 0 and no bit shows while accumulating.
    check_now("reset_ocrc_idle", ocrc, 1'b0);

    send_bits({24'h0, CMD0}, 40);
    check_now("ocrc_low_when_accumulating", ocrc, 1'b0);
    unload(7'h4A, 7);

    do_reset();
    send_bits({24'h0, CMD17}, 40);
    unload(7'h2A, 7);

    do_reset();
    send_bits({24'h0, RESP17}, 40);
    unload(7'h33, 7);

    // Back-to-back messages with no reset between them.
    do_reset();
    send_bits({24'h0, CMD17}, 40);
    unload(7'h2A, 7);
    send_bits({24'h0, CMD0}, 40);
    // Two extra unload cycles: bits past the seventh must read 0.
    unload(7'h4A, 9);

    // Check mode: message plus its correct CRC leaves a zero remainder.
    do_reset();
    send_bits({24'h0, CMD0}, 40);
    send_bits(64'h4A, 7);
    unload(7'h00, 7);

    // Flipping the final CRC bit flips the last feedback, leaving exactly POLY.
    do_reset();
    send_bits({24'h0, CMD0}, 40);
    send_bits(64'h4B, 7);
    unload(7'b0001001, 7);

    // Reset mid-message: asynchronous, ocrc forced low even with iunload high.
    do_reset();
    send_bits({44'h0, CMD17[39:20]}, 20);
    #2;
    irst    = 1'b0;
    iunload = 1'b1;
    #1;
    check_now("ocrc_in_async_reset", ocrc, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    check_now("ocrc_in_reset_after_clocks", ocrc, 1'b0);
    iunload = 1'b0;
    irst    = 1'b1;
    send_bits({24'h0, CMD0}, 40);
    unload(7'h4A, 7);

    // Drain: the monitor consumes each bit on the falling edge inside its cycle.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge iclk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL queue_drain: %0d bits left, expected 0", exp_q.size());
    end
    n_tests++;
    if (bit_idx != 7 * 8 + 2) begin
      n_fail++;
      $display("[TB] FAIL bit_count: got %0d unload samples, expected %0d", bit_idx, 7 * 8 + 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
